// File: rtl/mms_pkg.sv
// Shared definitions for motor_pulse_scheduler: config field codes, H-bridge
// drive patterns and the scheduler FSM encoding.
package mms_pkg;

  localparam logic [1:0] FLD_PERIOD = 2'd0;
  localparam logic [1:0] FLD_ON     = 2'd1;
  localparam logic [1:0] FLD_COUNT  = 2'd2;
  localparam logic [1:0] FLD_CTRL   = 2'd3;

  localparam logic [1:0] DRV_FWD   = 2'b10;
  localparam logic [1:0] DRV_REV   = 2'b01;
  localparam logic [1:0] DRV_COAST = 2'b00;
  localparam logic [1:0] DRV_BRAKE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [1:0] drive_pattern(input logic on, input logic dir);
    return on ? (dir ? DRV_REV : DRV_FWD) : DRV_COAST;
  endfunction

endpackage

// File: rtl/pulse_channel.sv
// One H-bridge driver: active timing registers, phase/pulse counters and the
// registered drive pattern. Define BRAKE_ON_IDLE_EN to brake finished drivers.
module pulse_channel
  import mms_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             commit,
  input  logic             start,
  input  logic             run,
  input  logic [CNT_W-1:0] sh_period,
  input  logic [CNT_W-1:0] sh_on,
  input  logic [CNT_W-1:0] sh_count,
  input  logic             sh_enable,
  input  logic             sh_dir,
  output logic [1:0]       drive,
  output logic             done_next
);

  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] act_on;
  logic [CNT_W-1:0] act_count;
  logic             act_enable;
  logic             act_dir;
  logic [CNT_W-1:0] ph;
  logic [CNT_W-1:0] pulses_left;
  logic             done;

  logic [CNT_W-1:0] src_period;
  logic [CNT_W-1:0] src_on;
  logic [CNT_W-1:0] src_count;
  logic             src_enable;
  logic             src_dir;
  logic             load_done;
  logic             wrap;
  logic [CNT_W-1:0] ph_inc;
  logic [CNT_W-1:0] ph_next;
  logic [1:0]       idle_pat;

  // A latch serviced on the start edge wins: the run uses the shadow values.
  assign src_period = commit ? sh_period : act_period;
  assign src_on     = commit ? sh_on     : act_on;
  assign src_count  = commit ? sh_count  : act_count;
  assign src_enable = commit ? sh_enable : act_enable;
  assign src_dir    = commit ? sh_dir    : act_dir;

  assign load_done = ~src_enable | (src_period == '0) | (src_count == '0);
  assign ph_inc    = ph + CNT_W'(1);
  assign wrap      = (ph_inc == act_period);
  assign ph_next   = wrap ? '0 : ph_inc;
  assign done_next = done | (wrap & (pulses_left == CNT_W'(1)));

`ifdef BRAKE_ON_IDLE_EN
  logic ran;
  assign idle_pat = ran ? DRV_BRAKE : DRV_COAST;
`else
  assign idle_pat = DRV_COAST;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_period  <= '0;
      act_on      <= '0;
      act_count   <= '0;
      act_enable  <= 1'b0;
      act_dir     <= 1'b0;
      ph          <= '0;
      pulses_left <= '0;
      done        <= 1'b1;
      drive       <= DRV_COAST;
`ifdef BRAKE_ON_IDLE_EN
      ran         <= 1'b0;
`endif
    end else begin
      if (commit) begin
        act_period <= sh_period;
        act_on     <= sh_on;
        act_count  <= sh_count;
        act_enable <= sh_enable;
        act_dir    <= sh_dir;
      end
      if (start) begin
        // Phase 0 is registered here so it shows the cycle after the trigger.
        ph          <= '0;
        pulses_left <= src_count;
        done        <= load_done;
        drive       <= load_done ? idle_pat : drive_pattern(src_on != '0, src_dir);
`ifdef BRAKE_ON_IDLE_EN
        if (!load_done) ran <= 1'b1;
`endif
      end else if (run && !done) begin
        ph <= ph_next;
        if (wrap) pulses_left <= pulses_left - CNT_W'(1);
        done  <= done_next;
        drive <= done_next ? idle_pat : drive_pattern(ph_next < act_on, act_dir);
      end
    end
  end

endmodule

// File: rtl/motor_pulse_scheduler.sv
// Per-driver pulse scheduler: shadow config, latch/trigger edge logic and the
// IDLE/RUN/DONE sequencer. Define BRAKE_ON_IDLE_EN to brake finished drivers.
module motor_pulse_scheduler
  import mms_pkg::*;
#(
  parameter int NUM_OF_DRIVERS = 8,
  parameter int CNT_W          = 16,
  parameter int IDX_W          = 3
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        cfg_we,
  input  logic [IDX_W+1:0]            cfg_addr,
  input  logic [CNT_W-1:0]            cfg_wdata,
  input  logic                        latch_data,
  input  logic                        control_trigger,
  output logic [2*NUM_OF_DRIVERS-1:0] driver_io,
  output logic                        update_cycle_complete,
  output logic                        busy
);

  state_t state;
  logic   trig_d;
  logic   latch_d;
  logic   latch_pending;
  logic   trig_edge;
  logic   latch_edge;
  logic   latch_req;
  logic   commit;
  logic   start;
  logic   run;
  logic   all_done;

  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_fld;
  logic             wr_ok;

  logic [CNT_W-1:0] sh_period [NUM_OF_DRIVERS];
  logic [CNT_W-1:0] sh_on     [NUM_OF_DRIVERS];
  logic [CNT_W-1:0] sh_count  [NUM_OF_DRIVERS];
  logic [1:0]       sh_ctrl   [NUM_OF_DRIVERS];

  logic [NUM_OF_DRIVERS-1:0] done_next;

  assign wr_idx = cfg_addr[IDX_W+1:2];
  assign wr_fld = cfg_addr[1:0];
  assign wr_ok  = cfg_we & ({1'b0, wr_idx} < (IDX_W+1)'(NUM_OF_DRIVERS));

  assign trig_edge  = control_trigger & ~trig_d;
  assign latch_edge = latch_data & ~latch_d;
  assign latch_req  = latch_pending | latch_edge;
  assign commit     = (state == IDLE) & latch_req;
  assign start      = (state == IDLE) & trig_edge;
  assign run        = (state == RUN);
  assign all_done   = &done_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_OF_DRIVERS; k++) begin
        sh_period[k] <= '0;
        sh_on[k]     <= '0;
        sh_count[k]  <= '0;
        sh_ctrl[k]   <= '0;
      end
    end else if (wr_ok) begin
      for (int k = 0; k < NUM_OF_DRIVERS; k++) begin
        if (wr_idx == IDX_W'(k)) begin
          case (wr_fld)
            FLD_PERIOD: sh_period[k] <= cfg_wdata;
            FLD_ON:     sh_on[k]     <= cfg_wdata;
            FLD_COUNT:  sh_count[k]  <= cfg_wdata;
            default:    sh_ctrl[k]   <= cfg_wdata[1:0];
          endcase
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_OF_DRIVERS; k++) begin : g_ch
    pulse_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .commit    (commit),
      .start     (start),
      .run       (run),
      .sh_period (sh_period[k]),
      .sh_on     (sh_on[k]),
      .sh_count  (sh_count[k]),
      .sh_enable (sh_ctrl[k][0]),
      .sh_dir    (sh_ctrl[k][1]),
      .drive     (driver_io[2*k+1:2*k]),
      .done_next (done_next[k])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      busy                  <= 1'b0;
      update_cycle_complete <= 1'b0;
      trig_d                <= 1'b0;
      latch_d               <= 1'b0;
      latch_pending         <= 1'b0;
    end else begin
      trig_d  <= control_trigger;
      latch_d <= latch_data;
      // A latch seen during RUN/DONE waits here until the next IDLE cycle.
      if (commit) latch_pending <= 1'b0;
      else if (latch_edge) latch_pending <= 1'b1;
      update_cycle_complete <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_edge) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (all_done) begin
            state                 <= DONE;
            busy                  <= 1'b0;
            update_cycle_complete <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
